// File: rtl/register_file_pkg.sv
// Shared types and elaboration helpers for the multi-read-port register file.
// Holds the sweep FSM state encoding and the parameter legality rules.
package register_file_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } rf_state_e;

  localparam int unsigned MIN_READ_PORTS = 1;
  localparam int unsigned MAX_READ_PORTS = 8;
  localparam int unsigned MIN_WIDTH      = 1;
  localparam int unsigned MIN_SELECT     = 1;
  localparam int unsigned MAX_SELECT     = 16;

  function automatic int unsigned depth_of(input int unsigned select_width);
    return 32'd1 << select_width;
  endfunction

  function automatic bit params_legal(input int unsigned width,
                                      input int unsigned select_width,
                                      input int unsigned read_ports);
    return (width >= MIN_WIDTH) &&
           (select_width >= MIN_SELECT) && (select_width <= MAX_SELECT) &&
           (read_ports >= MIN_READ_PORTS) && (read_ports <= MAX_READ_PORTS);
  endfunction

endpackage

// File: rtl/rf_read_port.sv
// One combinational read port: hardwired-zero entry, write-to-read forwarding,
// otherwise a plain mux over the stored entries.
module rf_read_port
  import register_file_pkg::*;
#(
  parameter int unsigned WIDTH        = 16,
  parameter int unsigned SELECT_WIDTH = 4,
  parameter bit          ZERO_REG     = 1'b1,
  parameter bit          BYPASS       = 1'b1,
  parameter int unsigned DEPTH        = depth_of(SELECT_WIDTH)
) (
  input  logic [SELECT_WIDTH-1:0]       raddr_i,
  input  logic [DEPTH-1:0][WIDTH-1:0]   entries_i,
  input  logic                          fwd_en_i,
  input  logic [SELECT_WIDTH-1:0]       waddr_i,
  input  logic [WIDTH-1:0]              wdata_i,
  output logic [WIDTH-1:0]              rdata_o
);

  // NOTE: every output of an always_comb gets a default first, so no path
  // through the if/else chain can leave it unassigned and infer a latch.
  always_comb begin
    rdata_o = entries_i[raddr_i];
    if (ZERO_REG && (raddr_i == '0)) begin
      rdata_o = '0;
    end else if (BYPASS && fwd_en_i && (waddr_i == raddr_i)) begin
      rdata_o = wdata_i;
    end
  end

endmodule

// File: rtl/register_file_mp.sv
// Single-write, multi-read register file with optional forwarding, optional
// hardwired-zero entry 0 and a one-entry-per-cycle background clear sweep.
module register_file_mp
  import register_file_pkg::*;
#(
  parameter int unsigned WIDTH        = 16,
  parameter int unsigned SELECT_WIDTH = 4,
  parameter int unsigned READ_PORTS   = 2,
  parameter bit          ZERO_REG     = 1'b1,
  parameter bit          BYPASS       = 1'b1
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  write,
  input  logic [SELECT_WIDTH-1:0]               Waddr,
  input  logic [WIDTH-1:0]                      W,
  input  logic [READ_PORTS-1:0][SELECT_WIDTH-1:0] raddr,
  output logic [READ_PORTS-1:0][WIDTH-1:0]      rdata,
  input  logic                                  clear,
  output logic                                  busy,
  output logic                                  write_dropped
);

  localparam int unsigned DEPTH = depth_of(SELECT_WIDTH);

  if (!params_legal(WIDTH, SELECT_WIDTH, READ_PORTS)) begin : g_bad_params
    $error("register_file_mp: illegal WIDTH/SELECT_WIDTH/READ_PORTS combination");
  end

  rf_state_e                     state_q;
  logic [SELECT_WIDTH-1:0]       ptr_q;
  logic                          busy_q;
  logic                          dropped_q;
  logic [DEPTH-1:0][WIDTH-1:0]   mem_q;
  logic [DEPTH-1:0][WIDTH-1:0]   mem_d;

  logic sweeping;
  logic fwd_en;
  logic wr_accept;

  always_comb begin
    sweeping  = (state_q == SWEEP);
    fwd_en    = write && !sweeping;
    wr_accept = fwd_en && !(ZERO_REG && (Waddr == '0));
  end

  // A sweep owns the write path: its clear of entry[ptr] replaces any write.
  always_comb begin
    mem_d = mem_q;
    if (sweeping) begin
      mem_d[ptr_q] = '0;
    end else if (wr_accept) begin
      mem_d[Waddr] = W;
    end
  end

  // NOTE: storage is reset like any other register because a reset must leave
  // every entry reading zero; this makes the array flops, not an SRAM macro.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  // NOTE: sequential state is written only with non-blocking assignments so
  // every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      busy_q    <= 1'b0;
      dropped_q <= 1'b0;
    end else begin
      dropped_q <= write && sweeping;
      unique case (state_q)
        IDLE: begin
          if (clear) begin
            state_q <= SWEEP;
            ptr_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        SWEEP: begin
          // clear is ignored here: a sweep in flight is neither restarted nor queued.
          ptr_q <= ptr_q + 1'b1;
          if (ptr_q == '1) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy          = busy_q;
  assign write_dropped = dropped_q;

  for (genvar i = 0; i < READ_PORTS; i++) begin : g_read_port
    rf_read_port #(
      .WIDTH        (WIDTH),
      .SELECT_WIDTH (SELECT_WIDTH),
      .ZERO_REG     (ZERO_REG),
      .BYPASS       (BYPASS),
      .DEPTH        (DEPTH)
    ) u_read_port (
      .raddr_i   (raddr[i]),
      .entries_i (mem_q),
      .fwd_en_i  (fwd_en),
      .waddr_i   (Waddr),
      .wdata_i   (W),
      .rdata_o   (rdata[i])
    );
  end

endmodule

// File: tb/tb_register_file_mp.sv
// Scoreboard bench: the driver pushes model predictions per cycle, a monitor
// pops them at the falling edge and compares against a forwarding and a non-forwarding build.
module tb_register_file_mp;

  localparam int WIDTH = 4;
  localparam int SW    = 3;
  localparam int RP    = 2;
  localparam int DEPTH = 8;

  logic                      clk = 1'b0;
  logic                      reset, write, clear;
  logic [SW-1:0]             Waddr;
  logic [WIDTH-1:0]          W;
  logic [RP-1:0][SW-1:0]     raddr;
  logic [RP-1:0][WIDTH-1:0]  rdata, rdata_nb;
  logic                      busy, write_dropped, busy_nb, dropped_nb;

  always #5 clk = ~clk;

  register_file_mp #(
    .WIDTH(WIDTH), .SELECT_WIDTH(SW), .READ_PORTS(RP), .ZERO_REG(1'b1), .BYPASS(1'b1)
  ) dut (
    .clk(clk), .reset(reset), .write(write), .Waddr(Waddr), .W(W),
    .raddr(raddr), .rdata(rdata), .clear(clear), .busy(busy),
    .write_dropped(write_dropped)
  );

  register_file_mp #(
    .WIDTH(WIDTH), .SELECT_WIDTH(SW), .READ_PORTS(RP), .ZERO_REG(1'b1), .BYPASS(1'b0)
  ) dut_nb (
    .clk(clk), .reset(reset), .write(write), .Waddr(Waddr), .W(W),
    .raddr(raddr), .rdata(rdata_nb), .clear(clear), .busy(busy_nb),
    .write_dropped(dropped_nb)
  );

  typedef struct {
    logic [WIDTH-1:0] r0, r1, n0, n1;
    logic             busy, dropped;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  // Reference model: contents, a "sweep in progress" flag with the next index
  // to clear, and the pending dropped-write pulse.
  int m_mem[DEPTH];
  bit m_sweep;
  int m_idx;
  bit m_dropped;

  function automatic logic [WIDTH-1:0] model_read(input int addr, input bit byp);
    if (addr == 0) return '0;
    if (byp && write && !m_sweep && (int'(Waddr) == addr)) return W;
    return WIDTH'(m_mem[addr]);
  endfunction

  task automatic model_edge();
    if (reset) begin
      foreach (m_mem[k]) m_mem[k] = 0;
      m_sweep   = 0;
      m_idx     = 0;
      m_dropped = 0;
    end else begin
      m_dropped = write && m_sweep;
      if (m_sweep) begin
        m_mem[m_idx] = 0;
        m_idx++;
        if (m_idx == DEPTH) m_sweep = 0;
      end else begin
        if (write && Waddr != 0) m_mem[Waddr] = int'(W);
        if (clear) begin
          m_sweep = 1;
          m_idx   = 0;
        end
      end
    end
  endtask

  task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cycle(input bit rst, input bit wr, input int wa, input int wd,
                       input bit clr, input int a0, input int a1, input bit chk);
    exp_t e;
    @(posedge clk);
    #1;
    reset    = rst;
    write    = wr;
    Waddr    = SW'(wa);
    W        = WIDTH'(wd);
    clear    = clr;
    raddr[0] = SW'(a0);
    raddr[1] = SW'(a1);
    if (chk) begin
      e.r0      = model_read(a0, 1'b1);
      e.r1      = model_read(a1, 1'b1);
      e.n0      = model_read(a0, 1'b0);
      e.n1      = model_read(a1, 1'b0);
      e.busy    = m_sweep;
      e.dropped = m_dropped;
      sb.push_back(e);
    end
    model_edge();
  endtask

  task automatic rd(input int a0, input int a1);
    cycle(0, 0, 0, 0, 0, a0, a1, 1);
  endtask

  task automatic wr(input int a, input int d, input int a0, input int a1);
    cycle(0, 1, a, d, 0, a0, a1, 1);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("rdata0",        rdata[0],                e.r0);
        check("rdata1",        rdata[1],                e.r1);
        check("rdata0_nobyp",  rdata_nb[0],             e.n0);
        check("rdata1_nobyp",  rdata_nb[1],             e.n1);
        check("busy",          WIDTH'(busy),            WIDTH'(e.busy));
        check("busy_nobyp",    WIDTH'(busy_nb),         WIDTH'(e.busy));
        check("write_dropped", WIDTH'(write_dropped),   WIDTH'(e.dropped));
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin : driver
    reset = 1'b1; write = 1'b0; clear = 1'b0; Waddr = '0; W = '0; raddr = '0;

    cycle(1, 0, 0, 0, 0, 0, 0, 0);
    cycle(1, 1, 2, 9, 1, 0, 0, 0);
    rd(1, 7);

    for (int i = 1; i < DEPTH; i++) wr(i, 15 - i, i, i - 1);
    wr(0, 15, 0, 0);
    for (int i = 0; i < DEPTH; i++) rd(i, DEPTH - 1 - i);

    wr(5, 'hA, 5, 4);
    rd(5, 4);

    for (int i = 0; i < DEPTH; i++) wr(i, 'hF, i, 0);
    cycle(0, 0, 0, 0, 1, 3, 7, 1);
    for (int k = 0; k < DEPTH; k++) begin
      if (k == 2)      cycle(0, 1, 6, 3, 0, 2, 3, 1);
      else if (k == 4) cycle(0, 0, 0, 0, 1, 6, 5, 1);
      else             rd(k, 7 - k);
    end
    rd(6, 3);
    rd(7, 1);

    for (int i = 1; i < DEPTH; i++) wr(i, i, i, 0);
    cycle(0, 0, 0, 0, 1, 1, 2, 1);
    rd(2, 3);
    rd(4, 5);
    rd(6, 7);
    cycle(1, 1, 2, 9, 0, 2, 1, 1);
    rd(2, 7);
    wr(4, 'h5, 4, 2);

    cycle(0, 1, 3, 7, 1, 3, 4, 1);
    for (int k = 0; k < DEPTH + 1; k++) rd(3, k);
    wr(3, 'h6, 3, 3);

    for (int n = 0; n < 2000; n++) begin
      cycle($urandom_range(0, 199) == 0, $urandom_range(0, 1) == 1,
            int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, 15)),
            $urandom_range(0, 24) == 0,
            int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, DEPTH - 1)), 1);
    end

    for (int w = 0; w < 5 && sb.size() > 0; w++) @(negedge clk);
    @(negedge clk);
    if (sb.size() > 0) begin
      tests++;
      fails++;
      $display("FAIL drain: %0d expected responses never compared, required 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
